// File: rtl/falc56_pkg.sv
// Shared types and constants for the FALC56 bus arbiter: FSM encoding,
// master IDs, idle pin values and the round-robin successor helper.
package falc56_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    localparam logic [1:0] M_WB   = 2'd0;
    localparam logic [1:0] M_DMA0 = 2'd1;
    localparam logic [1:0] M_DMA1 = 2'd2;

    typedef struct packed {
        logic       ale;
        logic       rdn;
        logic       wrn;
        logic [1:0] csn;
        logic [7:0] badd;
        logic       dir;
    } f56_pins_t;

    localparam logic [1:0] CSN_IDLE  = 2'b11;
    localparam f56_pins_t  PINS_IDLE = '{ale: 1'b0, rdn: 1'b1, wrn: 1'b1,
                                         csn: CSN_IDLE, badd: 8'h00, dir: 1'b0};

    function automatic logic [1:0] rr_next(input logic [1:0] idx);
        case (idx)
            M_WB:    return M_DMA0;
            M_DMA0:  return M_DMA1;
            default: return M_WB;
        endcase
    endfunction

endpackage

// File: rtl/falc56_rr_pick.sv
// Combinational 3-way round-robin picker: first set request at or after ptr,
// wrapping 2 -> 0.
module falc56_rr_pick
    import falc56_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       valid
);

    logic [1:0] cand;

    always_comb begin
        idx   = M_WB;
        valid = 1'b0;
        cand  = ptr;
        for (int unsigned k = 0; k < 3; k++) begin
            if (!valid && req[cand]) begin
                idx   = cand;
                valid = 1'b1;
            end
            cand = rr_next(cand);
        end
    end

endmodule

// File: rtl/falc56_bus_arbiter.sv
// Round-robin owner of the FALC56 parallel bus with registered pin muxing and
// turnaround idle cycles. Optional grant-hold timeout: define F56_ARB_TIMEOUT_EN.
module falc56_bus_arbiter
    import falc56_pkg::*;
#(
    parameter int N_REQ       = 3,
    parameter int TURN_CYCLES = 2,
    parameter int MAX_HOLD    = 64
) (
    input  logic                 FALC56_DCM_CLK0_I,
    input  logic                 PHY_RSTn_I,
    input  logic [N_REQ-1:0]     ARB_REQ_I,
    output logic [N_REQ-1:0]     ARB_GNT_O,
    input  logic [N_REQ-1:0]     ARB_EN_I,
    input  logic [N_REQ-1:0]     ARB_ALE_I,
    input  logic [N_REQ-1:0]     ARB_RDn_I,
    input  logic [N_REQ-1:0]     ARB_WRn_I,
    input  logic [2*N_REQ-1:0]   ARB_CSn_I,
    input  logic [8*N_REQ-1:0]   ARB_BADD_I,
    input  logic [N_REQ-1:0]     ARB_BADD_DIR_I,
    output logic                 F56_ALE_O,
    output logic                 F56_RDn_O,
    output logic                 F56_WRn_O,
    output logic [1:0]           F56_CSn_O,
    output logic [7:0]           F56_BADD_O,
    output logic                 F56_BADD_DIR_O,
    output logic [1:0]           ARB_OWNER_O,
    output logic                 ARB_BUSY_O,
    output logic                 ARB_TIMEOUT_O,
    output logic [1:0]           ARB_TIMEOUT_ID_O,
    input  logic                 ARB_TIMEOUT_CLR_I
);

    arb_state_t       state_q, state_n;
    logic [1:0]       ptr_q, owner_q, pick_idx;
    logic             pick_valid, owner_req, to_hit;
    logic [2:0]       turn_q;
    logic [N_REQ-1:0] req_eff, gnt_q, gnt_n;
    f56_pins_t        pins_q, pins_n, owner_pins;

    falc56_rr_pick u_pick (
        .req   (req_eff),
        .ptr   (ptr_q),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    assign owner_req  = ARB_REQ_I[owner_q];
    assign owner_pins = '{ale:  ARB_ALE_I[owner_q],
                          rdn:  ARB_RDn_I[owner_q],
                          wrn:  ARB_WRn_I[owner_q],
                          csn:  ARB_CSn_I[{owner_q, 1'b0} +: 2],
                          badd: ARB_BADD_I[{owner_q, 3'b000} +: 8],
                          dir:  ARB_BADD_DIR_I[owner_q]};

`ifdef F56_ARB_TIMEOUT_EN
    logic [7:0]       hold_q;
    logic [N_REQ-1:0] mask_q;
    logic             to_q;
    logic [1:0]       to_id_q;

    assign req_eff = ARB_REQ_I & ~mask_q;
    // A dropping request takes priority over the hold limit, so no flag is raised then.
    assign to_hit  = (state_q == ARB_GRANT) && owner_req && (hold_q == 8'(MAX_HOLD - 1));

    always_ff @(posedge FALC56_DCM_CLK0_I or negedge PHY_RSTn_I) begin
        if (!PHY_RSTn_I) begin
            hold_q  <= '0;
            mask_q  <= '0;
            to_q    <= 1'b0;
            to_id_q <= M_WB;
        end else begin
            hold_q <= (state_q == ARB_GRANT) ? hold_q + 8'd1 : '0;
            mask_q <= (mask_q & ARB_REQ_I) | (to_hit ? (N_REQ'(1) << owner_q) : '0);
            if (to_hit) begin
                to_q    <= 1'b1;
                to_id_q <= owner_q;
            end else if (ARB_TIMEOUT_CLR_I) begin
                to_q <= 1'b0;
            end
        end
    end

    assign ARB_TIMEOUT_O    = to_q;
    assign ARB_TIMEOUT_ID_O = to_id_q;
`else
    logic unused_tie;

    assign req_eff          = ARB_REQ_I;
    assign to_hit           = 1'b0;
    assign ARB_TIMEOUT_O    = 1'b0;
    assign ARB_TIMEOUT_ID_O = M_WB;
    assign unused_tie       = ^{ARB_TIMEOUT_CLR_I, 8'(MAX_HOLD)};
`endif

    always_ff @(posedge FALC56_DCM_CLK0_I or negedge PHY_RSTn_I) begin
        if (!PHY_RSTn_I) state_q <= ARB_IDLE;
        else             state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        case (state_q)
            ARB_IDLE:    if (pick_valid) state_n = ARB_GRANT;
            ARB_GRANT:   if (!owner_req || to_hit) state_n = ARB_RELEASE;
            ARB_RELEASE: if (turn_q == 3'(TURN_CYCLES - 1)) state_n = ARB_IDLE;
            default:     state_n = ARB_IDLE;
        endcase
    end

    always_comb begin
        gnt_n  = '0;
        pins_n = PINS_IDLE;
        if (state_q == ARB_IDLE && pick_valid) begin
            gnt_n = N_REQ'(1) << pick_idx;
        end else if (state_q == ARB_GRANT && state_n == ARB_GRANT) begin
            gnt_n = gnt_q;
            if (ARB_EN_I[owner_q]) pins_n = owner_pins;
        end
    end

    always_ff @(posedge FALC56_DCM_CLK0_I or negedge PHY_RSTn_I) begin
        if (!PHY_RSTn_I) begin
            gnt_q   <= '0;
            pins_q  <= PINS_IDLE;
            ptr_q   <= M_WB;
            owner_q <= M_WB;
            turn_q  <= '0;
        end else begin
            gnt_q  <= gnt_n;
            pins_q <= pins_n;
            turn_q <= (state_q == ARB_RELEASE) ? turn_q + 3'd1 : '0;
            if (state_q == ARB_IDLE && pick_valid) begin
                owner_q <= pick_idx;
                ptr_q   <= rr_next(pick_idx);
            end
        end
    end

    assign ARB_GNT_O      = gnt_q;
    assign F56_ALE_O      = pins_q.ale;
    assign F56_RDn_O      = pins_q.rdn;
    assign F56_WRn_O      = pins_q.wrn;
    assign F56_CSn_O      = pins_q.csn;
    assign F56_BADD_O     = pins_q.badd;
    assign F56_BADD_DIR_O = pins_q.dir;
    assign ARB_OWNER_O    = owner_q;
    assign ARB_BUSY_O     = (state_q == ARB_GRANT) || (state_q == ARB_RELEASE);

endmodule

// File: tb/tb_falc56_bus_arbiter.sv
// Randomised bench for falc56_bus_arbiter against a transaction-level bus
// ownership model, plus directed scenarios with literal expectations.
module tb_falc56_bus_arbiter;

    localparam int TURN = 2;
    localparam int MAXH = 8;
`ifdef F56_ARB_TIMEOUT_EN
    localparam bit TO_ON = 1'b1;
`else
    localparam bit TO_ON = 1'b0;
`endif
    localparam logic [13:0] IDLE_PINS = 14'b0_1_1_11_00000000_0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req, en, ale, rdn, wrn, dir;
    logic [5:0]  csn;
    logic [23:0] badd;
    logic        clr;
    logic [2:0]  gnt;
    logic        p_ale, p_rdn, p_wrn, p_dir, busy, to;
    logic [1:0]  p_csn, owner, to_id;
    logic [7:0]  p_badd;

    int n_checks = 0;
    int n_fail = 0;

    always #8 clk = ~clk;

    falc56_bus_arbiter #(.N_REQ(3), .TURN_CYCLES(TURN), .MAX_HOLD(MAXH)) dut (
        .FALC56_DCM_CLK0_I (clk),
        .PHY_RSTn_I        (rst_n),
        .ARB_REQ_I         (req),
        .ARB_GNT_O         (gnt),
        .ARB_EN_I          (en),
        .ARB_ALE_I         (ale),
        .ARB_RDn_I         (rdn),
        .ARB_WRn_I         (wrn),
        .ARB_CSn_I         (csn),
        .ARB_BADD_I        (badd),
        .ARB_BADD_DIR_I    (dir),
        .F56_ALE_O         (p_ale),
        .F56_RDn_O         (p_rdn),
        .F56_WRn_O         (p_wrn),
        .F56_CSn_O         (p_csn),
        .F56_BADD_O        (p_badd),
        .F56_BADD_DIR_O    (p_dir),
        .ARB_OWNER_O       (owner),
        .ARB_BUSY_O        (busy),
        .ARB_TIMEOUT_O     (to),
        .ARB_TIMEOUT_ID_O  (to_id),
        .ARB_TIMEOUT_CLR_I (clr)
    );

    // Model: who owns the bus, how many turnaround clocks remain, rotation pointer.
    int          m_owner, m_turn, m_last, m_ptr, m_hold, m_to_id;
    bit          m_mask [3];
    bit          m_to;
    logic [13:0] m_pins;
    logic [2:0]  m_gnt;

    function automatic logic [13:0] master_pins(input int i);
        return {ale[i], rdn[i], wrn[i], csn[2*i +: 2], badd[8*i +: 8], dir[i]};
    endfunction

    task automatic model_reset();
        m_owner = -1; m_turn = 0; m_last = 0; m_ptr = 0; m_hold = 0;
        m_to = 1'b0; m_to_id = 0; m_pins = IDLE_PINS; m_gnt = '0;
        for (int i = 0; i < 3; i++) m_mask[i] = 1'b0;
    endtask

    task automatic model_step();
        int  o;
        int  pick;
        bit  expired;
        o = m_owner;
        pick = -1;
        expired = 1'b0;
        m_pins = IDLE_PINS;
        if (o >= 0) begin
            if (!req[o] || (TO_ON && m_hold == MAXH - 1)) begin
                expired = req[o];
                m_owner = -1;
                m_turn = TURN;
            end else begin
                if (en[o]) m_pins = master_pins(o);
                m_hold++;
            end
        end else if (m_turn > 0) begin
            m_turn--;
        end else begin
            for (int k = 0; k < 3; k++) begin
                int i;
                i = (m_ptr + k) % 3;
                if (pick < 0 && req[i] && !m_mask[i]) pick = i;
            end
            if (pick >= 0) begin
                m_owner = pick; m_last = pick; m_ptr = (pick + 1) % 3; m_hold = 0;
            end
        end
        m_gnt = (m_owner >= 0) ? (3'b001 << m_owner) : 3'b000;
        if (TO_ON) begin
            for (int i = 0; i < 3; i++) if (!req[i]) m_mask[i] = 1'b0;
            if (expired) begin
                m_mask[o] = 1'b1; m_to = 1'b1; m_to_id = o;
            end else if (clr) begin
                m_to = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("gnt", 32'(gnt), 32'(m_gnt));
        chk("pins", 32'({p_ale, p_rdn, p_wrn, p_csn, p_badd, p_dir}), 32'(m_pins));
        chk("busy", 32'(busy), 32'(m_owner >= 0 || m_turn > 0));
        if (m_owner >= 0 || m_turn > 0) chk("owner", 32'(owner), 32'(m_last));
        chk("timeout", 32'(to), 32'(m_to));
        chk("timeout_id", 32'(to_id), 32'(m_to_id));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_inputs();
        req = '0; en = '0; ale = '0; rdn = '1; wrn = '1; dir = '0;
        csn = '1; badd = '0; clr = 1'b0;
    endtask

    int order[$];
    int gaps[$];

    initial begin
        int held, zero_run, cs_bad, cnt;
        logic [2:0] prev_gnt;
        idle_inputs();
        model_reset();
        repeat (3) @(negedge clk);
        chk("reset_gnt", 32'(gnt), 32'h0);
        chk("reset_pins", 32'({p_ale, p_rdn, p_wrn, p_csn, p_badd, p_dir}), 32'(IDLE_PINS));
        chk("reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;

        // Master 1 alone: grant after one clock, pins idle until it enables.
        req = 3'b010;
        ale[1] = 1'b1; rdn[1] = 1'b0; csn[3:2] = 2'b10; badd[15:8] = 8'h5A; dir[1] = 1'b1;
        tick();
        chk("t1_gnt", 32'(gnt), 32'h2);
        chk("t1_owner", 32'(owner), 32'h1);
        chk("t1_csn_idle", 32'(p_csn), 32'h3);
        en = 3'b010;
        tick();
        chk("t1_badd", 32'(p_badd), 32'h5A);
        chk("t1_csn", 32'(p_csn), 32'h2);
        req = '0;
        repeat (4) tick();

        // Owner 0 versus a busy non-owner 2.
        req = 3'b001; en = 3'b101;
        badd[7:0] = 8'hA5; csn[1:0] = 2'b10; wrn[0] = 1'b0; dir[0] = 1'b1;
        badd[23:16] = 8'h3C; csn[5:4] = 2'b01; dir[2] = 1'b1;
        repeat (2) tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("t3_badd", 32'(p_badd), 32'hA5);
            chk("t3_csn", 32'(p_csn), 32'h2);
        end
        chk("t3_wrn", 32'(p_wrn), 32'h0);

        // Asynchronous reset in the middle of a write.
        #3 rst_n = 1'b0;
        #1;
        chk("rst_wrn", 32'(p_wrn), 32'h1);
        chk("rst_csn", 32'(p_csn), 32'h3);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_dir", 32'(p_dir), 32'h0);
        model_reset();
        req = 3'b111; en = 3'b111;
        @(negedge clk);
        rst_n = 1'b1;

        // All masters requesting, each owner holds four clocks.
        held = 0; zero_run = 0; cs_bad = 0; prev_gnt = '0;
        for (int c = 0; c < 60 && order.size() < 5; c++) begin
            tick();
            if (gnt != 3'b000 && prev_gnt == 3'b000) begin
                order.push_back(gnt == 3'b001 ? 0 : gnt == 3'b010 ? 1 : gnt == 3'b100 ? 2 : 9);
                if (order.size() > 1) gaps.push_back(zero_run);
                zero_run = 0;
            end
            if (gnt == 3'b000) begin
                zero_run++;
                if (p_csn !== 2'b11) cs_bad++;
            end
            prev_gnt = gnt;
            req = 3'b111;
            if (m_owner >= 0) begin
                held++;
                if (held == 4) begin
                    req[m_owner] = 1'b0;
                    held = 0;
                end
            end else begin
                held = 0;
            end
        end
        if (order.size() < 4 || gaps.size() < 3) begin
            chk("rr_grants_seen", 32'(order.size()), 32'd4);
        end else begin
            chk("rr_order0", 32'(order[0]), 32'd0);
            chk("rr_order1", 32'(order[1]), 32'd1);
            chk("rr_order2", 32'(order[2]), 32'd2);
            chk("rr_order3", 32'(order[3]), 32'd0);
            for (int g = 0; g < 3; g++) chk("rr_gap", 32'(gaps[g]), 32'd3);
        end
        chk("rr_gap_csn", 32'(cs_bad), 32'd0);

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) if ($urandom_range(5) == 0) req[i] = ~req[i];
            en = 3'($urandom); ale = 3'($urandom); rdn = 3'($urandom); wrn = 3'($urandom);
            dir = 3'($urandom); csn = 6'($urandom); badd = 24'($urandom);
            clr = ($urandom_range(15) == 0);
            tick();
        end

`ifdef F56_ARB_TIMEOUT_EN
        idle_inputs();
        clr = 1'b1;
        repeat (6) tick();
        clr = 1'b0;
        req = 3'b010; en = 3'b010;
        cnt = 0;
        while (gnt != 3'b010 && cnt < 10) begin tick(); cnt++; end
        chk("to_granted", 32'(gnt), 32'h2);
        cnt = 1;
        while (gnt == 3'b010 && cnt < 20) begin tick(); cnt++; end
        chk("to_hold_clocks", 32'(cnt), 32'd8);
        chk("to_flag", 32'(to), 32'h1);
        chk("to_id", 32'(to_id), 32'h1);
        cs_bad = 0;
        for (int c = 0; c < 15; c++) begin tick(); if (gnt[1]) cs_bad++; end
        chk("to_masked", 32'(cs_bad), 32'd0);
        req = 3'b000; tick();
        req = 3'b010;
        cnt = 0;
        while (gnt != 3'b010 && cnt < 10) begin tick(); cnt++; end
        chk("to_regrant", 32'(gnt), 32'h2);
        clr = 1'b1; tick(); clr = 1'b0;
        chk("to_clr", 32'(to), 32'h0);
        req = 3'b000;
        repeat (5) tick();
        req = 3'b001;
        cnt = 0;
        while (!(m_owner >= 0 && m_hold == MAXH - 1) && cnt < 20) begin tick(); cnt++; end
        req = 3'b000;
        tick();
        chk("to_edge_gnt", 32'(gnt), 32'h0);
        chk("to_edge_flag", 32'(to), 32'h0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
